// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared 7-segment types, glyph table and lookup helper
package sevenseg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Active-low gfedcba patterns indexed by nibble value
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPH[nibble];
  endfunction

endpackage

// File: rtl/hex_glyph.sv
// rtl/hex_glyph.sv - combinational nibble plus decimal point to active-low segment byte
module hex_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg
);

  assign seg = {~dp, hex_to_seg(nibble)};

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - multi-digit 7-segment driver with blanking, blink and enable
module hex_display_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic                    enable,
  output logic [8*NUM_DIGITS-1:0] segments,
  output logic                    blink_phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [CNT_W-1:0]        blink_cnt;
  logic [NUM_DIGITS-1:0]   lz_hide;
  logic                    leading;
  seg_t                    glyph_seg [NUM_DIGITS];
  logic [8*NUM_DIGITS-1:0] next_segments;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
    end else if (load) begin
      shadow_value <= value;
      shadow_dp    <= dp;
    end
  end

  // Free-running blink timebase, deliberately independent of enable and load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_glyph
    hex_glyph u_glyph (
      .nibble (shadow_value[4*g +: 4]),
      .dp     (shadow_dp[g]),
      .seg    (glyph_seg[g])
    );
  end

  // A lit DP counts as significant so the scan stops there; digit 0 always shows
  always_comb begin
    lz_hide = '0;
    leading = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (shadow_value[4*i +: 4] == 4'h0) && !shadow_dp[i]) begin
        lz_hide[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end

  always_comb begin
    next_segments = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!enable) begin
        next_segments[8*i +: 8] = SEG_BLANK;
      end else if (blink_phase && blink_mask[i]) begin
        next_segments[8*i +: 8] = SEG_BLANK;
      end else if (lz_hide[i]) begin
        next_segments[8*i +: 8] = SEG_BLANK;
      end else begin
        next_segments[8*i +: 8] = glyph_seg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      segments <= '1;
    end else begin
      segments <= next_segments;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [23:0] value;
  logic [5:0]  dp;
  logic [5:0]  blink_mask;
  logic        lz_blank;
  logic        enable;
  logic [47:0] segments;
  logic        blink_phase;

  logic        load1;
  logic [3:0]  value1;
  logic        dp1;
  logic        mask1;
  logic        lz1;
  logic        en1;
  logic [7:0]  segments1;
  logic        blink_phase1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .value       (value),
    .dp          (dp),
    .blink_mask  (blink_mask),
    .lz_blank    (lz_blank),
    .enable      (enable),
    .segments    (segments),
    .blink_phase (blink_phase)
  );

  hex_display_ctrl #(.NUM_DIGITS(1), .BLINK_DIV(1)) dut1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load1),
    .value       (value1),
    .dp          (dp1),
    .blink_mask  (mask1),
    .lz_blank    (lz1),
    .enable      (en1),
    .segments    (segments1),
    .blink_phase (blink_phase1)
  );

  typedef struct {
    logic        lz;
    logic        en;
    logic [5:0]  dp;
    logic [23:0] value;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic lz, input logic en, input logic [5:0] d,
                              input logic [23:0] v, input logic [47:0] e);
    vec_t r;
    r.lz = lz; r.en = en; r.dp = d; r.value = v; r.exp = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic p;
    logic prev;
    bit   toggled;
    logic [7:0] b0;

    vecs[0]  = mk(1'b0, 1'b1, 6'h00, 24'h00A0F5, 48'hC0C0_88C0_8E92);
    vecs[1]  = mk(1'b1, 1'b1, 6'h00, 24'h000305, 48'hFFFF_FFB0_C092);
    vecs[2]  = mk(1'b1, 1'b1, 6'h00, 24'h000000, 48'hFFFF_FFFF_FFC0);
    vecs[3]  = mk(1'b1, 1'b1, 6'h02, 24'h000005, 48'hFFFF_FFFF_4092);
    vecs[4]  = mk(1'b0, 1'b1, 6'h00, 24'h000000, 48'hC0C0_C0C0_C0C0);
    vecs[5]  = mk(1'b1, 1'b1, 6'h00, 24'h123456, 48'hF9A4_B099_9282);
    vecs[6]  = mk(1'b1, 1'b1, 6'h00, 24'h00789A, 48'hFFFF_F880_9888);
    vecs[7]  = mk(1'b1, 1'b1, 6'h00, 24'h0BCDEF, 48'hFF83_C6A1_868E);
    vecs[8]  = mk(1'b1, 1'b1, 6'h00, 24'h100000, 48'hF9C0_C0C0_C0C0);
    vecs[9]  = mk(1'b1, 1'b1, 6'h3F, 24'h000000, 48'h4040_4040_4040);
    vecs[10] = mk(1'b1, 1'b0, 6'h00, 24'h123456, 48'hFFFF_FFFF_FFFF);

    // Reset held with a load pending; enable low keeps the display dark afterwards
    reset_n = 1'b0; load = 1'b1; value = 24'h123456; dp = '0;
    blink_mask = '0; lz_blank = 1'b0; enable = 1'b0;
    load1 = 1'b1; value1 = 4'h1; dp1 = 1'b0; mask1 = 1'b1; lz1 = 1'b0; en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_segments", 64'(segments), 64'hFFFF_FFFF_FFFF);
      chk("reset_phase", 64'(blink_phase), 64'h0);
      chk("reset_segments1", 64'(segments1), 64'hFF);
    end
    reset_n = 1'b1; load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_reset_dark", 64'(segments), 64'hFFFF_FFFF_FFFF);
    end

    for (int i = 0; i < 11; i++) begin
      value = vecs[i].value; dp = vecs[i].dp;
      lz_blank = vecs[i].lz; enable = vecs[i].en; load = 1'b1;
      step();
      load = 1'b0;
      step();
      chk($sformatf("vec%0d", i), 64'(segments), 64'(vecs[i].exp));
    end

    // Shadow holds while load is low even as value changes
    value = 24'h00A0F5; dp = '0; lz_blank = 1'b0; enable = 1'b1; load = 1'b1;
    step();
    load = 1'b0; value = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load_hold", 64'(segments), 64'hC0C0_88C0_8E92);
    end

    // Load held high captures every edge
    load = 1'b1; value = 24'h111111;
    step();
    value = 24'h222222;
    step();
    chk("load_high_a", 64'(segments), 64'hF9F9_F9F9_F9F9);
    load = 1'b0;
    step();
    chk("load_high_b", 64'(segments), 64'hA4A4_A4A4_A4A4);

    // Disable together with a load, then re-enable
    enable = 1'b0; load = 1'b1; value = 24'h111111;
    step();
    load = 1'b0;
    chk("disable_dark", 64'(segments), 64'hFFFF_FFFF_FFFF);
    step();
    chk("disable_dark_hold", 64'(segments), 64'hFFFF_FFFF_FFFF);
    enable = 1'b1;
    step();
    chk("reenable", 64'(segments), 64'hF9F9_F9F9_F9F9);

    // Blink on digit 0 with a 4-clock half-period
    value = 24'h000001; blink_mask = 6'b000001; lz_blank = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    prev = blink_phase;
    toggled = 1'b0;
    for (int i = 0; i < 8 && !toggled; i++) begin
      step();
      if (blink_phase !== prev) toggled = 1'b1;
    end
    chk("blink_toggle_seen", 64'(toggled), 64'h1);
    p = blink_phase;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk($sformatf("blink_phase_j%0d", j), 64'(blink_phase), 64'(p ^ ((j / 4) % 2 == 1)));
      b0 = (p ^ (((j - 1) / 4) % 2 == 1)) ? 8'hFF : 8'hF9;
      chk($sformatf("blink_seg_j%0d", j), 64'(segments), 64'({40'hC0C0_C0C0_C0, b0}));
    end
    blink_mask = '0;

    // Reset on the same edge as a load wins and leaves shadow cleared
    reset_n = 1'b0; load = 1'b1; value = 24'h999999; enable = 1'b1;
    step();
    chk("reset_vs_load_seg", 64'(segments), 64'hFFFF_FFFF_FFFF);
    chk("reset_vs_load_phase", 64'(blink_phase), 64'h0);
    reset_n = 1'b1; load = 1'b0; lz_blank = 1'b0;
    // Single-digit, divide-by-one instance: phase toggles every clock from reset
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 1) chk("reset_vs_load_shadow", 64'(segments), 64'hC0C0_C0C0_C0C0);
      chk($sformatf("div1_phase_j%0d", j), 64'(blink_phase1), 64'(j % 2));
      if (j >= 2)
        chk($sformatf("div1_seg_j%0d", j), 64'(segments1), ((j - 1) % 2 == 1) ? 64'hFF : 64'hF9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
